// File: rtl/sample_packer.sv
// Packs 1-bit I/Q sample pairs into 2*SAMPLES-bit words.
// Each word is staged for one cycle, then queued in a 2-entry valid/ready
// output FIFO. m_tlast marks the last word of every FRAME-word frame.
// Words that arrive while the FIFO is full and not draining are dropped;
// each drop is recorded in a sticky overflow flag and a saturating counter.
module sample_packer #(
  parameter int SAMPLES = 8,
  parameter int FRAME   = 64
) (
  input  logic                 clk16,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 strobe,
  input  logic                 data_i,
  input  logic                 data_q,
  input  logic                 clear,
  output logic [2*SAMPLES-1:0] m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic                 overflow,
  output logic [7:0]           drops
);

  localparam int WW   = 2 * SAMPLES;
  localparam int IDXW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int FRMW = (FRAME > 1) ? $clog2(FRAME) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic              capture, abort, last_slot, complete;
  logic [IDXW-1:0]   sample_idx_q;
  logic [FRMW-1:0]   frame_cnt_q;
  logic [WW-1:0]     word_q;
  logic              pend_q, pend_last_q;
  logic [WW-1:0]     mem_q [2];
  logic              last_mem_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;
  logic              pop, full, push_ok, drop;
  logic              overflow_q;
  logic [7:0]        drops_q;

  // State register of the capture FSM
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Enable moves between IDLE and FILL
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = FILL;
      FILL:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes only count while filling with enable still high; dropping enable aborts the word
  always_comb begin
    capture = 1'b0;
    abort   = 1'b0;
    if (state_q == FILL) begin
      capture = en && strobe;
      abort   = !en;
    end
  end

  assign last_slot = (sample_idx_q == IDXW'(SAMPLES - 1));
  assign complete  = capture && last_slot;

  // Slot capture, word staging and frame position tracking
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      sample_idx_q <= '0;
      frame_cnt_q  <= '0;
      word_q       <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      pend_q      <= complete;
      pend_last_q <= complete && (frame_cnt_q == FRMW'(FRAME - 1));
      if (abort) begin
        sample_idx_q <= '0;
        frame_cnt_q  <= '0;
      end else if (capture) begin
        word_q[{sample_idx_q, 1'b0} +: 2] <= {data_q, data_i};
        if (last_slot) begin
          sample_idx_q <= '0;
          frame_cnt_q  <= (frame_cnt_q == FRMW'(FRAME - 1)) ? '0 : frame_cnt_q + 1'b1;
        end else begin
          sample_idx_q <= sample_idx_q + 1'b1;
        end
      end
    end
  end

  assign m_tvalid = (count_q != 2'd0);
  assign full     = (count_q == 2'd2);
  assign pop      = m_tvalid && m_tready;
  assign push_ok  = pend_q && (!full || pop);
  assign drop     = pend_q && full && !pop;
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m_tlast  = m_tvalid && last_mem_q[rd_ptr_q];

  // Two-entry output FIFO; a full FIFO being popped still accepts a push
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i]      <= '0;
        last_mem_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q]      <= word_q;
        last_mem_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Overflow bookkeeping; a drop in the same cycle as clear is still recorded
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drops_q    <= 8'd0;
    end else if (clear) begin
      overflow_q <= drop;
      drops_q    <= {7'd0, drop};
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drops_q != 8'hFF) drops_q <= drops_q + 8'd1;
    end
  end

  assign overflow = overflow_q;
  assign drops    = drops_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed testbench for sample_packer (SAMPLES=8, FRAME=64).
// Inputs change on the falling edge and outputs are sampled there too,
// so every check sits half a cycle away from the capturing rising edge.
module tb_sample_packer;

  logic        clk16 = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        strobe = 1'b0;
  logic        data_i = 1'b0;
  logic        data_q = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        overflow;
  logic [7:0]  drops;

  int checkCount = 0;
  int errorCount = 0;

  sample_packer #(.SAMPLES(8), .FRAME(64)) dut (
    .clk16(clk16), .rst_n(rst_n), .en(en), .strobe(strobe),
    .data_i(data_i), .data_q(data_q), .clear(clear),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .overflow(overflow), .drops(drops)
  );

  // 16 MHz-style free-running clock, 10 ns period
  always #5 clk16 = ~clk16;

  // Watchdog so the bench always ends on its own
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic i, input logic q);
    strobe = s;
    data_i = i;
    data_q = q;
    @(negedge clk16);
  endtask

  task automatic sendSample(input logic i, input logic q);
    applyStimulus(1'b1, i, q);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Sends eight samples taken from w (bit 2k = I, bit 2k+1 = Q); the push cycle can carry clear/ready overrides
  task automatic sendWord(input logic [15:0] w, input logic clearOnPush, input logic readyOnPush);
    logic savedReady;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, w[2*k], w[2*k+1]);
      if (k == 7) begin
        savedReady = m_tready;
        if (readyOnPush) m_tready = 1'b1;
        clear = clearOnPush;
        applyStimulus(1'b0, 1'b0, 1'b0);
        m_tready = savedReady;
        clear = 1'b0;
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    int firstLast;
    logic staleSeen;

    $display("[TB] reset and first word");
    #3;
    checkOutput("rstValid", m_tvalid, 1'b0);
    checkOutput("rstData", m_tdata, 16'h0000);
    checkOutput("rstLast", m_tlast, 1'b0);
    checkOutput("rstOverflow", overflow, 1'b0);
    checkOutput("rstDrops", drops, 8'd0);
    @(negedge clk16);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) sendSample(1'b1, 1'b0);
    checkOutput("validBeforeLast", m_tvalid, 1'b0);
    sendSample(1'b1, 1'b0);
    checkOutput("w0Valid", m_tvalid, 1'b1);
    checkOutput("w0Data", m_tdata, 16'h5555);
    checkOutput("w0Last", m_tlast, 1'b0);

    $display("[TB] alternating pattern through one frame");
    for (int w = 1; w < 64; w++) begin
      for (int k = 0; k < 8; k++) sendSample(k % 2 == 0, k % 2 == 0);
      checkOutput("altData", m_tdata, 16'h3333);
      checkOutput("altLast", m_tlast, w == 63);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drained", m_tvalid, 1'b0);

    $display("[TB] backpressure, simultaneous pop/push, drop and clear");
    m_tready = 1'b0;
    sendWord(16'h5555, 1'b0, 1'b0);
    checkOutput("bpA", m_tdata, 16'h5555);
    sendWord(16'hAAAA, 1'b0, 1'b0);
    checkOutput("bpHeldA", m_tdata, 16'h5555);
    checkOutput("bpNoOvf", overflow, 1'b0);
    sendWord(16'hFFFF, 1'b0, 1'b1);
    checkOutput("bpPopPushHead", m_tdata, 16'hAAAA);
    checkOutput("bpPopPushOvf", overflow, 1'b0);
    sendWord(16'h0000, 1'b0, 1'b0);
    checkOutput("bpHeldB", m_tdata, 16'hAAAA);
    checkOutput("bpOverflow", overflow, 1'b1);
    checkOutput("bpDrops", drops, 8'd1);
    m_tready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bpSecond", m_tdata, 16'hFFFF);
    checkOutput("bpSecondValid", m_tvalid, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bpEmpty", m_tvalid, 1'b0);
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    checkOutput("clrOverflow", overflow, 1'b0);
    checkOutput("clrDrops", drops, 8'd0);

    $display("[TB] enable abort mid-word");
    for (int k = 0; k < 5; k++) sendSample(1'b0, 1'b1);
    en = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) sendSample(k[0], k[1]);
    checkOutput("abortData", m_tdata, 16'hE4E4);
    checkOutput("abortLast", m_tlast, 1'b0);
    firstLast = -1;
    for (int w = 1; w < 64; w++) begin
      sendWord(16'hC3C3, 1'b0, 1'b0);
      if (m_tlast && firstLast < 0) firstLast = w;
    end
    checkOutput("abortFrameIdx", firstLast, 63);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] drop counter saturation");
    m_tready = 1'b0;
    for (int w = 1; w <= 300; w++) begin
      sendWord((w == 1) ? 16'h1234 : 16'h5A5A, w == 20, 1'b0);
      if (w == 2) begin
        checkOutput("satFullOvf", overflow, 1'b0);
        checkOutput("satFullDrops", drops, 8'd0);
      end
      if (w == 10) checkOutput("satDrops10", drops, 8'd8);
      if (w == 20) begin
        checkOutput("clrDropOvf", overflow, 1'b1);
        checkOutput("clrDropDrops", drops, 8'd1);
      end
      if (w == 273) checkOutput("satDrops254", drops, 8'd254);
      if (w == 274) checkOutput("satDrops255", drops, 8'd255);
    end
    checkOutput("satHold", drops, 8'd255);
    checkOutput("satHeadStable", m_tdata, 16'h1234);

    $display("[TB] asynchronous reset mid-word");
    m_tready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    m_tready = 1'b0;
    checkOutput("preRstOneWord", m_tdata, 16'h5A5A);
    for (int k = 0; k < 3; k++) sendSample(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncValid", m_tvalid, 1'b0);
    checkOutput("asyncData", m_tdata, 16'h0000);
    checkOutput("asyncLast", m_tlast, 1'b0);
    checkOutput("asyncOverflow", overflow, 1'b0);
    checkOutput("asyncDrops", drops, 8'd0);
    @(negedge clk16);
    rst_n = 1'b1;
    m_tready = 1'b1;
    staleSeen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      staleSeen = staleSeen | m_tvalid;
    end
    checkOutput("noStaleWord", staleSeen, 1'b0);
    sendWord(16'h0F0F, 1'b0, 1'b0);
    checkOutput("postRstData", m_tdata, 16'h0F0F);
    checkOutput("postRstLast", m_tlast, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 SHALL have parameter SAMPLES, default 8, meaning I/Q sample pairs packed per output word (2..32).
REQ-002 SHALL have parameter FRAME, default 64, meaning output words per frame; m_tlast marks the last word of each frame.
REQ-003 SHALL have input clk16, 1 bit, system clock (16 MHz).
REQ-004 SHALL have input rst_n, 1 bit, reset: asynchronous, active-low.
REQ-005 SHALL have input en, 1 bit, capture enable.
REQ-006 SHALL have input strobe, 1 bit, one-cycle sample-valid pulse (nominal 8 MHz, every 2nd clk16).
REQ-007 SHALL have inputs data_i and data_q, 1 bit each, registered I/Q bits from the radio capture stage.
REQ-008 SHALL have input clear, 1 bit, clears the overflow flag and the drop counter.
REQ-009 SHALL have output m_tdata, 2*SAMPLES bits: bit 2k = I of sample k, bit 2k+1 = Q of sample k; k=0 is the oldest sample.
REQ-010 SHALL have outputs m_tvalid and m_tlast (1 bit each) and input m_tready (1 bit): valid/ready stream.
REQ-011 SHALL have outputs overflow (1 bit, sticky) and drops (8 bits, saturating count of dropped words).

Function
REQ-012 SHALL implement FSM IDLE/FILL: IDLE -> FILL on en=1; FILL -> IDLE on en=0.
REQ-013 In FILL, each cycle with strobe=1 SHALL capture {data_q,data_i} into slot sample_idx and increment sample_idx.
REQ-014 Strobe in IDLE, or in the same cycle as the IDLE->FILL transition, SHALL be ignored.
REQ-015 On the strobe that fills slot SAMPLES-1, the completed word SHALL be pushed to a 2-entry output FIFO and sample_idx SHALL wrap to 0.
REQ-016 Latency: last sample captured at edge k -> word on m_tdata with m_tvalid=1 after edge k+1.
REQ-017 A FIFO entry SHALL transfer on m_tvalid & m_tready; m_tdata and m_tlast SHALL be held stable while m_tvalid=1 and m_tready=0.
REQ-018 Push into a full FIFO with m_tready=1 in the same cycle SHALL succeed (simultaneous pop and push); with m_tready=0 the new word SHALL be dropped.
REQ-019 A drop SHALL set overflow=1 and increment drops, saturating at 255.
REQ-020 clear SHALL zero overflow and drops; a clear coinciding with a drop SHALL give overflow=1, drops=1.
REQ-021 The word counter (0..FRAME-1) SHALL advance on every completed word, dropped or not; m_tlast=1 for the word at index FRAME-1; the counter SHALL wrap to 0.
REQ-022 en=0 in FILL SHALL discard the partial word and zero sample_idx and the word counter; FIFO contents already queued SHALL remain and drain normally.
REQ-023 m_tvalid SHALL NOT depend combinationally on m_tready.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state IDLE, sample_idx=0, word counter=0, FIFO empty, m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, drops=0.
REQ-025 Reset mid-word or mid-frame SHALL lose all partial and queued data; the first word after reset SHALL start at slot 0, frame index 0.

Verification
REQ-026 SAMPLES=8, m_tready=1, en=1, strobe every 2nd cycle, I=1/Q=0 for all samples -> m_tdata=16'h5555 one cycle after the 8th strobe.
REQ-027 Alternating sample I/Q = (1,1),(0,0) -> m_tdata=16'h3333; words 0..62 have m_tlast=0 and word 63 has m_tlast=1.
REQ-028 m_tready=0 for 3 complete words -> 2 words held stable, overflow=1, drops=1; release ready -> 2 words emitted in order; clear -> overflow=0, drops=0.
REQ-029 en dropped after 5 strobes and re-raised -> partial word discarded; next word built from 8 fresh samples, frame index 0.
REQ-030 rst_n pulsed low mid-word with FIFO holding 1 word -> all outputs 0 immediately, no stale word emitted after release.
REQ-031 m_tready=0 for 300 word times -> drops saturates at 255 and does not wrap.
